// File: rtl/reg_mux_nx1.sv
// N:1 registered channel multiplexer feeding a 2-entry in-order output buffer.
// Out-of-range selects produce zero data and raise a sticky sel_err flag.
module reg_mux_nx1 #(
  parameter int W  = 23,
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] ctrl,
  input  logic [N*W-1:0] D,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  S,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sel_err,
  input  logic          clr_err
);

  // Handshake: a push happens on an edge where in_valid && in_ready, a pop on
  // an edge where out_valid && out_ready; both may happen on the same edge.

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q, in_ready_d;
  logic         sel_err_q, sel_err_d;

  logic [W-1:0] sel_val;
  logic         sel_oor;
  logic         push;
  logic         pop;

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(ctrl) == 32'(k)) sel_val = D[k*W +: W];
    end
    sel_oor = (32'(ctrl) >= 32'(N));
  end

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  // head_q is the visible entry; it keeps its value when the buffer empties.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push && pop) begin
      if (count_q == 2'd1) begin
        head_d = sel_val;
      end else begin
        head_d = tail_q;
        tail_d = sel_val;
      end
    end else if (push) begin
      if (count_q == 2'd0) head_d = sel_val;
      else                 tail_d = sel_val;
      count_d = count_q + 2'd1;
    end else if (pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      count_d = count_q - 2'd1;
    end
    in_ready_d = (count_d != 2'd2);
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (push && sel_oor) sel_err_d = 1'b1;
    else if (clr_err)    sel_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign S         = head_q;
  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_reg_mux_nx1.sv
// Directed checks of reg_mux_nx1 at default parameters plus a seeded soak
// against a reference queue on an N=5, W=8, SW=3 instance.
module tb_reg_mux_nx1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default-parameter instance
  logic [1:0]  ctrl = '0;
  logic [68:0] D    = '0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic        sel_err, clr_err = 1'b0;
  logic [22:0] S;

  reg_mux_nx1 u_dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .D(D), .in_valid(in_valid),
    .in_ready(in_ready), .S(S), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .clr_err(clr_err)
  );

  // Soak instance
  logic [2:0]  ctrl2 = '0;
  logic [39:0] D2    = '0;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic        sel_err2, clr_err2 = 1'b0;
  logic [7:0]  S2;
  logic [7:0]  exp_q[$];

  reg_mux_nx1 #(.W(8), .N(5), .SW(3)) u_soak (
    .clk(clk), .rst(rst), .ctrl(ctrl2), .D(D2), .in_valid(in_valid2),
    .in_ready(in_ready2), .S(S2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sel_err(sel_err2), .clr_err(clr_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (S !== 23'h0) begin n_fail++; $display("FAIL rst_S: got 0x%0h expected 0x0", S); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_sel_err: got %b expected 0", sel_err); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    D = {23'h7FFFFF, 23'h2AAAAA, 23'h000001};
    out_ready = 1'b1; ctrl = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_tests++; if (S !== 23'h2AAAAA) begin n_fail++; $display("FAIL basic_S: got 0x%0h expected 0x2aaaaa", S); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
    n_tests++; if (S !== 23'h2AAAAA) begin n_fail++; $display("FAIL basic_hold: got 0x%0h expected 0x2aaaaa", S); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; ctrl = 2'd0; in_valid = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
    n_tests++; if (S !== 23'h000001) begin n_fail++; $display("FAIL bp_S1: got 0x%0h expected 0x1", S); end
    ctrl = 2'd2;
    tick();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b expected 0", in_ready); end
    ctrl = 2'd1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (S !== 23'h000001) begin n_fail++; $display("FAIL bp_stable: got 0x%0h expected 0x1", S); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (S !== 23'h7FFFFF) begin n_fail++; $display("FAIL bp_S2: got 0x%0h expected 0x7fffff", S); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid2: got %b expected 1", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_third: got %b expected 0", out_valid); end
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1; ctrl = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (S !== 23'h0) begin n_fail++; $display("FAIL oor_S: got 0x%0h expected 0x0", S); end
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL oor_set: got %b expected 1", sel_err); end
    tick();
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b expected 1", sel_err); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_clear: got %b expected 0", sel_err); end
    in_valid = 1'b1;
    tick();
    clr_err = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL oor_set_wins: got %b expected 1", sel_err); end
    tick();
    clr_err = 1'b0;
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_clear2: got %b expected 0", sel_err); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; ctrl = 2'd0; in_valid = 1'b1;
    tick();
    out_ready = 1'b1; ctrl = 2'd2;
    tick();
    in_valid = 1'b0;
    n_tests++; if (S !== 23'h7FFFFF) begin n_fail++; $display("FAIL b2b_S: got 0x%0h expected 0x7fffff", S); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_occ1: got %b expected 1", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; ctrl = 2'd1;
    tick();
    ctrl = 2'd3;
    tick();
    in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b expected 0", in_ready); end
    n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL mid_err: got %b expected 1", sel_err); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (S !== 23'h0) begin n_fail++; $display("FAIL mid_S: got 0x%0h expected 0x0", S); end
    n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL mid_sel_err: got %b expected 0", sel_err); end
    #2 rst = 1'b1;
    out_ready = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_data: got %b expected 0", out_valid); end
      tick();
    end
  endtask

  task automatic test_soak();
    logic [7:0] exp_val;
    logic       do_push, do_pop;
    for (int c = 0; c < 600; c++) begin
      in_valid2  = ($urandom_range(0, 3) != 0);
      out_ready2 = ($urandom_range(0, 2) != 0);
      ctrl2      = 3'($urandom_range(0, 7));
      D2[31:0]   = $urandom();
      D2[39:32]  = 8'($urandom());
      #1;
      n_tests++;
      if (out_valid2 !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL soak_valid c=%0d: got %b expected %b", c, out_valid2, exp_q.size() != 0);
      end
      do_push = in_valid2 && in_ready2;
      do_pop  = out_valid2 && out_ready2;
      if (do_pop && exp_q.size() != 0) begin
        exp_val = exp_q.pop_front();
        n_tests++;
        if (S2 !== exp_val) begin
          n_fail++;
          $display("FAIL soak_data c=%0d: got 0x%0h expected 0x%0h", c, S2, exp_val);
        end
      end
      if (do_push) begin
        exp_val = (ctrl2 < 3'd5) ? D2[int'(ctrl2)*8 +: 8] : 8'h00;
        exp_q.push_back(exp_val);
      end
      tick();
    end
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid2) begin
        exp_val = exp_q.pop_front();
        n_tests++;
        if (S2 !== exp_val) begin
          n_fail++;
          $display("FAIL soak_drain: got 0x%0h expected 0x%0h", S2, exp_val);
        end
      end
      tick();
    end
    n_tests++;
    if (exp_q.size() != 0 || out_valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL soak_leftover: got %0d queued, out_valid %b expected 0 and 0", exp_q.size(), out_valid2);
    end
  endtask

  initial begin
    void'($urandom(32'd1234));
    test_reset();
    test_basic();
    test_backpressure();
    test_sel_err();
    test_back_to_back();
    test_reset_mid();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
